// File: rtl/spi_fpmul_pkg.sv
// Shared opcodes, status bit positions and command FSM states for the SPI
// front end of the fp multiplier.
`timescale 1ns/1ps
package spi_fpmul_pkg;

   localparam logic [7:0] CMD_WR_X1   = 8'h01;
   localparam logic [7:0] CMD_WR_X2   = 8'h02;
   localparam logic [7:0] CMD_START   = 8'h03;
   localparam logic [7:0] CMD_RD_Y    = 8'h04;
   localparam logic [7:0] CMD_RD_STAT = 8'h05;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_WR   = 3'd2,
      S_RD   = 3'd3,
      S_EXEC = 3'd4,
      S_DONE = 3'd5
   } state_e;

   // Status byte as it appears on the wire.
   function automatic logic [7:0] stat_byte(input logic [2:0] st);
      return {5'b00000, st};
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the asynchronous SPI pins into the clk domain and turns them
// into single-cycle sck/cs edge pulses plus an aligned mosi sample.
`timescale 1ns/1ps
module spi_edge_sync #(
   parameter int SYNC_LEN = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sck_i,
   input  logic mosi_i,
   input  logic cs_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic mosi_o
);

   logic [SYNC_LEN-1:0] sck_q, mosi_q, cs_q;
   logic                sck_prev_q, cs_prev_q;

   // Synchroniser chains; cs resets low so a frame already open is not re-entered.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sck_q      <= '0;
         mosi_q     <= '0;
         cs_q       <= '0;
         sck_prev_q <= 1'b0;
         cs_prev_q  <= 1'b0;
      end else begin
         sck_q      <= {sck_q[SYNC_LEN-2:0], sck_i};
         mosi_q     <= {mosi_q[SYNC_LEN-2:0], mosi_i};
         cs_q       <= {cs_q[SYNC_LEN-2:0], cs_i};
         sck_prev_q <= sck_q[SYNC_LEN-1];
         cs_prev_q  <= cs_q[SYNC_LEN-1];
      end
   end

   assign sck_rise_o = sck_q[SYNC_LEN-1] & ~sck_prev_q;
   assign sck_fall_o = ~sck_q[SYNC_LEN-1] & sck_prev_q;
   assign cs_fall_o  = ~cs_q[SYNC_LEN-1] & cs_prev_q;
   assign cs_rise_o  = cs_q[SYNC_LEN-1] & ~cs_prev_q;
   assign mosi_o     = mosi_q[SYNC_LEN-1];

endmodule

// File: rtl/spi_fpmul_cmd_slave.sv
// SPI mode-0 command slave: loads x1/x2, starts the multiplier, returns y and
// a sticky status byte, and raises irq while a result is pending.
`timescale 1ns/1ps
module spi_fpmul_cmd_slave
   import spi_fpmul_pkg::*;
#(
   parameter int FP_W     = 16,
   parameter int SYNC_LEN = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            sck_i,
   input  logic            mosi_i,
   input  logic            cs_i,
   output logic            miso_o,
   output logic [FP_W-1:0] x1_o,
   output logic [FP_W-1:0] x2_o,
   output logic            en_o,
   input  logic [FP_W-1:0] y_i,
   input  logic            ready_i,
   output logic            irq_o
);

   localparam int               CNT_W  = $clog2(FP_W);
   localparam logic [CNT_W-1:0] LAST_W = CNT_W'(FP_W - 1);

   logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, mosi_s;

   spi_edge_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .sck_i      (sck_i),
      .mosi_i     (mosi_i),
      .cs_i       (cs_i),
      .sck_rise_o (sck_rise_s),
      .sck_fall_o (sck_fall_s),
      .cs_fall_o  (cs_fall_s),
      .cs_rise_o  (cs_rise_s),
      .mosi_o     (mosi_s)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, rd_last_q, rd_last_d;
   logic [FP_W-1:0]  rx_q, rx_d, tx_q, tx_d, x1_q, x1_d, x2_q, x2_d, y_q, y_d;
   logic [FP_W-1:0]  rx_shift_s;
   logic [2:0]       status_q, status_d;
   logic             wr_x2_q, wr_x2_d, rd_stat_q, rd_stat_d;
   logic             en_q, en_d, miso_q, miso_d, irq_q;

   assign rx_shift_s = {rx_q[FP_W-2:0], mosi_s};

   // Command FSM, payload shifting and status update.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      status_d  = status_q;
      wr_x2_d   = wr_x2_q;
      rd_last_d = rd_last_q;
      rd_stat_d = rd_stat_q;
      en_d      = 1'b0;
      miso_d    = 1'b0;
      if (cs_rise_s) begin
         state_d = S_IDLE;
      end else if (cs_fall_s) begin
         state_d   = S_CMD;
         bit_cnt_d = '0;
         rx_d      = '0;
      end else begin
         case (state_q)
            S_CMD: begin
               if (sck_rise_s) begin
                  rx_d      = rx_shift_s;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CNT_W'(7)) begin
                     bit_cnt_d = '0;
                     rx_d      = '0;
                     case (rx_shift_s[7:0])
                        CMD_WR_X1: begin
                           state_d = S_WR;
                           wr_x2_d = 1'b0;
                        end
                        CMD_WR_X2: begin
                           state_d = S_WR;
                           wr_x2_d = 1'b1;
                        end
                        CMD_START: begin
                           state_d = S_EXEC;
                           if (status_q[ST_BUSY]) begin
                              status_d[ST_ERR] = 1'b1;
                           end else begin
                              en_d              = 1'b1;
                              status_d[ST_BUSY] = 1'b1;
                              status_d[ST_DONE] = 1'b0;
                           end
                        end
                        CMD_RD_Y: begin
                           state_d   = S_RD;
                           tx_d      = y_q;
                           rd_last_d = LAST_W;
                           rd_stat_d = 1'b0;
                        end
                        CMD_RD_STAT: begin
                           state_d   = S_RD;
                           tx_d      = {stat_byte(status_q), {(FP_W-8){1'b0}}};
                           rd_last_d = CNT_W'(7);
                           rd_stat_d = 1'b1;
                        end
                        default: begin
                           state_d          = S_DONE;
                           status_d[ST_ERR] = 1'b1;
                        end
                     endcase
                  end else begin
                     state_d = S_CMD;
                  end
               end else begin
                  state_d = S_CMD;
               end
            end
            S_WR: begin
               if (sck_rise_s) begin
                  rx_d      = rx_shift_s;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == LAST_W) begin
                     state_d = S_DONE;
                     if (wr_x2_q) begin
                        x2_d = rx_shift_s;
                     end else begin
                        x1_d = rx_shift_s;
                     end
                     // Operands changing under a running multiply is flagged, not blocked.
                     status_d[ST_ERR] = status_q[ST_ERR] | status_q[ST_BUSY];
                  end else begin
                     state_d = S_WR;
                  end
               end else begin
                  state_d = S_WR;
               end
            end
            S_RD: begin
               if (sck_fall_s) begin
                  miso_d = tx_q[FP_W-1];
                  tx_d   = {tx_q[FP_W-2:0], 1'b0};
               end else begin
                  miso_d = miso_q;
               end
               if (sck_rise_s) begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == rd_last_q) begin
                     state_d = S_DONE;
                     if (rd_stat_q) begin
                        status_d[ST_DONE] = 1'b0;
                        status_d[ST_ERR]  = 1'b0;
                     end else begin
                        status_d[ST_ERR] = status_q[ST_ERR];
                     end
                  end else begin
                     state_d = S_RD;
                  end
               end else begin
                  state_d = S_RD;
               end
            end
            S_IDLE, S_EXEC, S_DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      // Applied after the read-clear so a same-cycle result keeps done set.
      if (status_q[ST_BUSY] && ready_i) begin
         y_d               = y_i;
         status_d[ST_BUSY] = 1'b0;
         status_d[ST_DONE] = 1'b1;
      end else begin
         y_d = y_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         x1_q      <= '0;
         x2_q      <= '0;
         y_q       <= '0;
         status_q  <= 3'b000;
         wr_x2_q   <= 1'b0;
         rd_last_q <= '0;
         rd_stat_q <= 1'b0;
         en_q      <= 1'b0;
         miso_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         x1_q      <= x1_d;
         x2_q      <= x2_d;
         y_q       <= y_d;
         status_q  <= status_d;
         wr_x2_q   <= wr_x2_d;
         rd_last_q <= rd_last_d;
         rd_stat_q <= rd_stat_d;
         en_q      <= en_d;
         miso_q    <= miso_d;
         irq_q     <= status_d[ST_DONE];
      end
   end

   assign miso_o = miso_q;
   assign x1_o   = x1_q;
   assign x2_o   = x2_q;
   assign en_o   = en_q;
   assign irq_o  = irq_q;

endmodule

// File: tb/tb_spi_fpmul_cmd_slave.sv
// Directed bench for spi_fpmul_cmd_slave: a 16-bit and a 32-bit instance share
// sck/mosi, each with its own cs and a small delayed-ready multiplier model.
`timescale 1ns/1ps
module tb_spi_fpmul_cmd_slave;

   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        rst_n, sck, mosi, cs0, cs1;
   logic        miso0, miso1, en0, en1, irq0, irq1;
   logic [15:0] x1_0, x2_0, y0;
   logic [31:0] x1_1, x2_1, y1;
   logic        mod_rdy0 = 1'b0, mod_rdy1 = 1'b0, man_rdy0;
   logic        rdy0, rdy1;
   int          mdelay0, mdelay1;
   int          cnt0 = 0, cnt1 = 0, en_cnt0 = 0, en_cnt1 = 0;
   int          n_err, n_chk;

   always #5 clk = ~clk;

   assign rdy0 = mod_rdy0 | man_rdy0;
   assign rdy1 = mod_rdy1;

   spi_fpmul_cmd_slave #(.FP_W(16), .SYNC_LEN(2)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .mosi_i(mosi), .cs_i(cs0),
      .miso_o(miso0), .x1_o(x1_0), .x2_o(x2_0), .en_o(en0),
      .y_i(y0), .ready_i(rdy0), .irq_o(irq0)
   );

   spi_fpmul_cmd_slave #(.FP_W(32), .SYNC_LEN(2)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .mosi_i(mosi), .cs_i(cs1),
      .miso_o(miso1), .x1_o(x1_1), .x2_o(x2_1), .en_o(en1),
      .y_i(y1), .ready_i(rdy1), .irq_o(irq1)
   );

   // Multiplier models: count en pulses, pulse ready mdelay clocks after en (0 = never).
   always @(posedge clk) begin
      mod_rdy0 <= 1'b0;
      if (en0) begin
         en_cnt0 <= en_cnt0 + 1;
         cnt0    <= mdelay0;
      end else if (cnt0 > 1) begin
         cnt0 <= cnt0 - 1;
      end else if (cnt0 == 1) begin
         cnt0     <= 0;
         mod_rdy0 <= 1'b1;
      end
   end

   always @(posedge clk) begin
      mod_rdy1 <= 1'b0;
      if (en1) begin
         en_cnt1 <= en_cnt1 + 1;
         cnt1    <= mdelay1;
      end else if (cnt1 > 1) begin
         cnt1 <= cnt1 - 1;
      end else if (cnt1 == 1) begin
         cnt1     <= 0;
         mod_rdy1 <= 1'b1;
      end
   end

   typedef struct {
      int          dut;
      logic [7:0]  cmd;
      logic [31:0] data;
      int          pay;
      logic [31:0] exp_rd;
      logic [31:0] exp_x1;
      logic [31:0] exp_x2;
      int          exp_en;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One mode-0 frame: 8 command bits then pay bits of data, MSB first.
   task automatic spi_frame(input int sel, input logic [7:0] cmd, input logic [31:0] data,
                            input int pay, input bit raise_cs, input bit rdy_last,
                            output logic [31:0] rx);
      logic b;
      rx = '0;
      @(posedge clk);
      #2;
      if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
      #HALF;
      for (int i = 0; i < 8 + pay; i++) begin
         if (i < 8) b = cmd[7-i];
         else       b = data[pay-1-(i-8)];
         mosi = b;
         #HALF;
         if (i >= 8) rx = {rx[30:0], (sel == 0) ? miso0 : miso1};
         sck = 1'b1;
         if (rdy_last && (i == 8 + pay - 1)) begin
            // Lands ready on the clock where the synchronised last rise is acted on.
            @(posedge clk);
            @(posedge clk);
            #1 man_rdy0 = 1'b1;
            @(posedge clk);
            #1 man_rdy0 = 1'b0;
         end
         #HALF;
         sck = 1'b0;
      end
      mosi = 1'b0;
      #HALF;
      if (raise_cs) begin
         cs0 = 1'b1;
         cs1 = 1'b1;
         #(2*HALF);
      end
   endtask

   task automatic wait_irq(input int sel, input int max);
      int k = 0;
      while ((((sel == 0) ? irq0 : irq1) !== 1'b1) && (k < max)) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rx;
      int          base;
      int          k;
      n_err = 0; n_chk = 0;
      sck = 1'b0; mosi = 1'b0; cs0 = 1'b1; cs1 = 1'b1; man_rdy0 = 1'b0;
      y0 = 16'h4000; y1 = 32'h4000_0000; mdelay0 = 5; mdelay1 = 5;
      rst_n = 1'b0;

      //          dut cmd    data          pay exp_rd        x1            x2            en irq
      tbl[0]  = '{0, 8'h05, 32'h0,        8,  32'h00,       32'h0,        32'h0,        0, 1'b0};
      tbl[1]  = '{0, 8'h01, 32'h3C00,     16, 32'h0,        32'h3C00,     32'h0,        0, 1'b0};
      tbl[2]  = '{0, 8'h02, 32'h4000,     16, 32'h0,        32'h3C00,     32'h4000,     0, 1'b0};
      tbl[3]  = '{0, 8'h03, 32'h0,        0,  32'h0,        32'h3C00,     32'h4000,     1, 1'b1};
      tbl[4]  = '{0, 8'h04, 32'h0,        16, 32'h4000,     32'h3C00,     32'h4000,     1, 1'b1};
      tbl[5]  = '{0, 8'h05, 32'h0,        8,  32'h02,       32'h3C00,     32'h4000,     1, 1'b0};
      tbl[6]  = '{0, 8'h05, 32'h0,        8,  32'h00,       32'h3C00,     32'h4000,     1, 1'b0};
      tbl[7]  = '{0, 8'h7F, 32'hFFFF,     16, 32'h0,        32'h3C00,     32'h4000,     1, 1'b0};
      tbl[8]  = '{0, 8'h05, 32'h0,        8,  32'h04,       32'h3C00,     32'h4000,     1, 1'b0};
      tbl[9]  = '{0, 8'h05, 32'h0,        8,  32'h00,       32'h3C00,     32'h4000,     1, 1'b0};
      tbl[10] = '{1, 8'h01, 32'h3F800000, 32, 32'h0,        32'h3F800000, 32'h0,        0, 1'b0};
      tbl[11] = '{1, 8'h02, 32'h40000000, 32, 32'h0,        32'h3F800000, 32'h40000000, 0, 1'b0};
      tbl[12] = '{1, 8'h03, 32'h0,        0,  32'h0,        32'h3F800000, 32'h40000000, 1, 1'b1};
      tbl[13] = '{1, 8'h04, 32'h0,        32, 32'h40000000, 32'h3F800000, 32'h40000000, 1, 1'b1};
      tbl[14] = '{1, 8'h05, 32'h0,        8,  32'h02,       32'h3F800000, 32'h40000000, 1, 1'b0};
      tbl[15] = '{1, 8'h05, 32'h0,        8,  32'h00,       32'h3F800000, 32'h40000000, 1, 1'b0};

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_x1_16", {16'h0, x1_0}, 32'h0);
      check("rst_x2_16", {16'h0, x2_0}, 32'h0);
      check("rst_en_irq_miso_16", {29'h0, en0, irq0, miso0}, 32'h0);
      check("rst_x1_32", x1_1, 32'h0);
      check("rst_en_irq_miso_32", {29'h0, en1, irq1, miso1}, 32'h0);

      for (int i = 0; i < 16; i++) begin
         spi_frame(tbl[i].dut, tbl[i].cmd, tbl[i].data, tbl[i].pay, 1'b1, 1'b0, rx);
         if (tbl[i].exp_irq) wait_irq(tbl[i].dut, 200);
         check($sformatf("vec%0d_rd", i), rx, tbl[i].exp_rd);
         check($sformatf("vec%0d_x1", i), (tbl[i].dut == 0) ? {16'h0, x1_0} : x1_1, tbl[i].exp_x1);
         check($sformatf("vec%0d_x2", i), (tbl[i].dut == 0) ? {16'h0, x2_0} : x2_1, tbl[i].exp_x2);
         check($sformatf("vec%0d_en", i), (tbl[i].dut == 0) ? en_cnt0 : en_cnt1, tbl[i].exp_en);
         check($sformatf("vec%0d_irq", i), {31'h0, (tbl[i].dut == 0) ? irq0 : irq1},
               {31'h0, tbl[i].exp_irq});
      end

      // Truncated WR_X1 payload is discarded, then a full one lands.
      spi_frame(0, 8'h01, 32'h1FF, 9, 1'b1, 1'b0, rx);
      check("t3_partial_x1_16", {16'h0, x1_0}, 32'h3C00);
      spi_frame(0, 8'h01, 32'h1234, 16, 1'b1, 1'b0, rx);
      check("t3_full_x1_16", {16'h0, x1_0}, 32'h1234);
      spi_frame(1, 8'h01, 32'h1FF, 9, 1'b1, 1'b0, rx);
      check("t3_partial_x1_32", x1_1, 32'h3F800000);
      spi_frame(1, 8'h01, 32'h12345678, 32, 1'b1, 1'b0, rx);
      check("t3_full_x1_32", x1_1, 32'h12345678);

      // Double START: one en, err sticky; the 0x05 read clears err, so done alone follows.
      mdelay0 = 600;
      base = en_cnt0;
      spi_frame(0, 8'h03, 32'h0, 0, 1'b1, 1'b0, rx);
      spi_frame(0, 8'h03, 32'h0, 0, 1'b1, 1'b0, rx);
      check("t2a_single_en", en_cnt0 - base, 32'd1);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b0, rx);
      check("t2a_stat_busy_err", rx, 32'h05);
      wait_irq(0, 2000);
      check("t2a_irq", {31'h0, irq0}, 32'h1);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b0, rx);
      check("t2a_stat_done", rx, 32'h02);

      // Double START left unread until the result arrives: err and done together.
      base = en_cnt0;
      spi_frame(0, 8'h03, 32'h0, 0, 1'b1, 1'b0, rx);
      spi_frame(0, 8'h03, 32'h0, 0, 1'b1, 1'b0, rx);
      check("t2b_single_en", en_cnt0 - base, 32'd1);
      wait_irq(0, 2000);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b0, rx);
      check("t2b_stat_err_done", rx, 32'h06);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b0, rx);
      check("t2b_stat_clear", rx, 32'h00);

      // Ready coincides with the status read-clear: done must survive.
      mdelay0 = 0;
      y0 = 16'h5A5A;
      base = en_cnt0;
      spi_frame(0, 8'h03, 32'h0, 0, 1'b1, 1'b0, rx);
      check("t6_en", en_cnt0 - base, 32'd1);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b1, rx);
      check("t6_stat_busy", rx, 32'h01);
      check("t6_irq_kept", {31'h0, irq0}, 32'h1);
      spi_frame(0, 8'h04, 32'h0, 16, 1'b1, 1'b0, rx);
      check("t6_rd_y", rx, 32'h5A5A);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b0, rx);
      check("t6_stat_done", rx, 32'h02);
      check("t6_irq_cleared", {31'h0, irq0}, 32'h0);

      // Reset in the middle of an RD_Y frame while the multiplier is busy.
      mdelay0 = 400;
      spi_frame(0, 8'h03, 32'h0, 0, 1'b1, 1'b0, rx);
      spi_frame(0, 8'h04, 32'h0, 3, 1'b0, 1'b0, rx);
      check("t5_miso_before_rst", {31'h0, miso0}, 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("t5_rst_x1", {16'h0, x1_0}, 32'h0);
      check("t5_rst_x2", {16'h0, x2_0}, 32'h0);
      check("t5_rst_en_irq_miso", {29'h0, en0, irq0, miso0}, 32'h0);
      check("t5_rst_x1_32", x1_1, 32'h0);
      rst_n = 1'b1;
      cs0 = 1'b1;
      #(2*HALF);
      k = 0;
      while (mod_rdy0 !== 1'b1 && k < 1000) begin
         @(posedge clk);
         k++;
      end
      check("t5_late_ready_seen", {31'h0, mod_rdy0}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("t5_irq_after_late_ready", {31'h0, irq0}, 32'h0);
      spi_frame(0, 8'h05, 32'h0, 8, 1'b1, 1'b0, rx);
      check("t5_stat", rx, 32'h00);
      spi_frame(0, 8'h04, 32'h0, 16, 1'b1, 1'b0, rx);
      check("t5_rd_y", rx, 32'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
